// File: rtl/window_motor_scheduler.sv
// Motor scheduler for NUM_WIN car windows: request resolution, round-robin slot arbitration,
// end-stop / timeout / dead-time enforcement. Tap-to-auto mode is built when WINDOW_SCHED_AUTO_MODE_EN is defined.
module window_motor_scheduler #(
    parameter int NUM_WIN     = 4,
    parameter int MAX_ACTIVE  = 2,
    parameter int MAX_RUN     = 1000,
    parameter int DEAD_CYCLES = 8,
    parameter int AUTO_TICKS  = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_WIN-1:0] drv_up,
    input  logic [NUM_WIN-1:0] drv_dn,
    input  logic [NUM_WIN-1:0] loc_up,
    input  logic [NUM_WIN-1:0] loc_dn,
    input  logic               lock,
    input  logic [NUM_WIN-1:0] top,
    input  logic [NUM_WIN-1:0] bot,
    output logic [NUM_WIN-1:0] mot_up,
    output logic [NUM_WIN-1:0] mot_dn,
    output logic [NUM_WIN-1:0] busy,
    output logic [NUM_WIN-1:0] fault
);

    localparam int TW = $clog2(MAX_RUN + DEAD_CYCLES + AUTO_TICKS + 1);
    localparam int PW = $clog2(NUM_WIN);
    localparam int CW = $clog2(NUM_WIN + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_COOL
`ifdef WINDOW_SCHED_AUTO_MODE_EN
        , ST_AUTO
`endif
    } state_t;

    state_t             state_q [NUM_WIN];
    state_t             state_d [NUM_WIN];
    logic [TW-1:0]      tmr_q   [NUM_WIN];
    logic [TW-1:0]      tmr_d   [NUM_WIN];
    logic [NUM_WIN-1:0] dir_q, dir_d;       // 1 = up
    logic [NUM_WIN-1:0] fault_q, fault_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      act_q, act_d;
    logic [NUM_WIN-1:0] mot_up_q, mot_up_d;
    logic [NUM_WIN-1:0] mot_dn_q, mot_dn_d;
    logic [NUM_WIN-1:0] busy_q, busy_d;

    logic [NUM_WIN-1:0] req_v, req_up;
    logic [NUM_WIN-1:0] gnt;
    logic [NUM_WIN-1:0] stop_end, tmo;
    logic               found;
    int                 idx;

    function automatic logic is_running(input state_t s);
`ifdef WINDOW_SCHED_AUTO_MODE_EN
        return (s == ST_RUN) || (s == ST_AUTO);
`else
        return (s == ST_RUN);
`endif
    endfunction

    // Driver panel beats local switch; a request into an asserted end-stop is dropped.
    always_comb begin
        req_v  = '0;
        req_up = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (drv_up[w] ^ drv_dn[w]) begin
                req_v[w]  = 1'b1;
                req_up[w] = drv_up[w];
            end else if ((loc_up[w] ^ loc_dn[w]) && !(lock && (w != 0))) begin
                req_v[w]  = 1'b1;
                req_up[w] = loc_up[w];
            end
            if (req_v[w] && ((req_up[w] && top[w]) || (!req_up[w] && bot[w]))) begin
                req_v[w] = 1'b0;
            end
        end
    end

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        rr_d  = rr_q;
        if (int'(act_q) < MAX_ACTIVE) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                idx = (int'(rr_q) + i) % NUM_WIN;
                if (!found && (state_q[idx] == ST_WAIT) && req_v[idx] &&
                    (req_up[idx] == dir_q[idx])) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    rr_d     = PW'((idx + 1) % NUM_WIN);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        dir_d    = dir_q;
        fault_d  = fault_q;
        stop_end = '0;
        tmo      = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            stop_end[w] = dir_q[w] ? top[w] : bot[w];
            tmo[w]      = (tmr_q[w] == TW'(MAX_RUN - 1));
            case (state_q[w])
                ST_IDLE: begin
                    if (!req_v[w]) begin
                        fault_d[w] = 1'b0;
                    end else if (!fault_q[w]) begin
                        dir_d[w]   = req_up[w];
                        state_d[w] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req_v[w] || (req_up[w] != dir_q[w])) begin
                        state_d[w] = ST_IDLE;
                    end else if (gnt[w]) begin
                        state_d[w] = ST_RUN;
                        tmr_d[w]   = '0;
                    end
                end
                ST_RUN: begin
                    tmr_d[w] = tmr_q[w] + 1'b1;
                    if (stop_end[w] || tmo[w]) begin
                        state_d[w] = ST_COOL;
                        tmr_d[w]   = '0;
                        if (tmo[w]) fault_d[w] = 1'b1;
                    end else if (!req_v[w]) begin
`ifdef WINDOW_SCHED_AUTO_MODE_EN
                        if (tmr_q[w] < TW'(AUTO_TICKS)) begin
                            state_d[w] = ST_AUTO;
                        end else begin
                            state_d[w] = ST_COOL;
                            tmr_d[w]   = '0;
                        end
`else
                        state_d[w] = ST_COOL;
                        tmr_d[w]   = '0;
`endif
                    end else if (req_up[w] != dir_q[w]) begin
                        state_d[w] = ST_COOL;
                        tmr_d[w]   = '0;
                    end
                end
`ifdef WINDOW_SCHED_AUTO_MODE_EN
                ST_AUTO: begin
                    tmr_d[w] = tmr_q[w] + 1'b1;
                    if (stop_end[w] || tmo[w] || req_v[w]) begin
                        state_d[w] = ST_COOL;
                        tmr_d[w]   = '0;
                        if (tmo[w]) fault_d[w] = 1'b1;
                    end
                end
`endif
                ST_COOL: begin
                    if (tmr_q[w] == TW'(DEAD_CYCLES - 1)) begin
                        state_d[w] = ST_IDLE;
                        tmr_d[w]   = '0;
                    end else begin
                        tmr_d[w] = tmr_q[w] + 1'b1;
                    end
                end
                default: begin
                    state_d[w] = ST_IDLE;
                    tmr_d[w]   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        act_d    = '0;
        mot_up_d = '0;
        mot_dn_d = '0;
        busy_d   = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (is_running(state_d[w])) begin
                act_d       = act_d + CW'(1);
                mot_up_d[w] = dir_d[w];
                mot_dn_d[w] = !dir_d[w];
            end
            busy_d[w] = (state_d[w] != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= '{default: ST_IDLE};
            tmr_q    <= '{default: '0};
            dir_q    <= '0;
            fault_q  <= '0;
            rr_q     <= '0;
            act_q    <= '0;
            mot_up_q <= '0;
            mot_dn_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            dir_q    <= dir_d;
            fault_q  <= fault_d;
            rr_q     <= rr_d;
            act_q    <= act_d;
            mot_up_q <= mot_up_d;
            mot_dn_q <= mot_dn_d;
            busy_q   <= busy_d;
        end
    end

    assign mot_up = mot_up_q;
    assign mot_dn = mot_dn_q;
    assign busy   = busy_q;
    assign fault  = fault_q;

endmodule
